instruction_fetch_unit: RTL

Fetch stage of the RISC-V processor, sitting directly upstream of the control unit and register file. Holds the program counter, issues instruction-memory requests over a valid/ready handshake, captures each returned word into an instruction register and presents it with its opcode field until the downstream datapath retires it. On retirement it advances the PC by 4 or redirects to a taken-branch target.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/fetch_pc_reg.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: major opcodes, the canonical NOP and the fetch FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus: request handshake plus response word.
interface instruction_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection between sequential +4 and an aligned branch target.
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc
);
    import riscv_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // The +4 path wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = branch_taken ? align_word(branch_target) : pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues one imem request per instruction, holds the returned word until the datapath retires it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                            clk,
    input  logic                            reset,
    instruction_fetch_unit_if.master        imem,
    input  logic                            stall,
    input  logic                            branch_taken,
    input  logic [31:0]                     branch_target,
    output logic                            instr_valid,
    output logic [31:0]                     instr,
    output logic [6:0]                      opcode,
    output logic [31:0]                     pc,
    output logic [31:0]                     retire_count
);
    import riscv_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         req_valid_q;
    logic         req_valid_d;
    logic         instr_valid_q;
    logic         instr_valid_d;
    logic [31:0]  instr_q;
    logic [31:0]  instr_d;
    logic [31:0]  retire_count_q;
    logic [31:0]  retire_count_d;
    logic         retire;
    logic [31:0]  pc_q;

    // req_valid is a registered decode of the next state, so it never sees imem_req_ready combinationally.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        retire_count_d = retire_count_q;
        retire         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (req_valid_q && imem.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    instr_d       = imem.imem_rsp_data;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    retire         = 1'b1;
                    instr_d        = NOP_INSTR;
                    instr_valid_d  = 1'b0;
                    retire_count_d = retire_count_q + 32'd1;
                    state_d        = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        req_valid_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_FETCH;
            req_valid_q    <= 1'b0;
            instr_valid_q  <= 1'b0;
            instr_q        <= NOP_INSTR;
            retire_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            req_valid_q    <= req_valid_d;
            instr_valid_q  <= instr_valid_d;
            instr_q        <= instr_d;
            retire_count_q <= retire_count_d;
        end
    end

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .load_en      (retire),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc_q)
    );

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = pc_q;
    assign instr_valid         = instr_valid_q;
    assign instr               = instr_q;
    assign opcode              = instr_q[6:0];
    assign pc                  = pc_q;
    assign retire_count        = retire_count_q;

endmodule
